// File: rtl/wb_daq_sram_writer_pkg.sv
// Shared DAQ SRAM-writer definitions: FSM encoding, default widths, byte-select constant.
package wb_daq_sram_writer_pkg;
  localparam int         AW_DEF  = 32;
  localparam int         LW_DEF  = 16;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE,
    ST_FULL
  } wr_state_e;
endpackage

// File: rtl/wb_daq_sram_writer_if.sv
// Wishbone master bus bundle used between the DAQ SRAM writer and the interconnect.
interface wb_daq_sram_writer_if #(parameter int AW = 32);
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [3:0]    wbm_sel_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic          wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_ack_i
  );
endinterface

// File: rtl/wb_daq_wr_pointer.sv
// Window write pointer: offset counter, terminal compare, wrap/full sticky flags, buffer-done pulse.
module wb_daq_wr_pointer #(
  parameter int LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          adv_i,
  input  logic          wrap_en_i,
  input  logic [LW-1:0] length_i,
  output logic [LW-1:0] offset_o,
  output logic          last_o,
  output logic          full_o,
  output logic          wrapped_o,
  output logic          buffer_done_o
);

  logic [LW-1:0] offset_q, offset_d;
  logic          full_q, full_d;
  logic          wrapped_q, wrapped_d;
  logic          bd_q, bd_d;

  assign last_o = (offset_q == length_i - LW'(1));

  always_comb begin
    offset_d  = offset_q;
    full_d    = full_q;
    wrapped_d = wrapped_q;
    bd_d      = 1'b0;
    if (clear_i) begin
      offset_d  = '0;
      full_d    = 1'b0;
      wrapped_d = 1'b0;
    end else if (adv_i) begin
      if (last_o) begin
        bd_d = 1'b1;
        // non-wrap keeps offset at the last slot so it never exceeds length-1
        if (wrap_en_i) begin
          offset_d  = '0;
          wrapped_d = 1'b1;
        end else begin
          full_d = 1'b1;
        end
      end else begin
        offset_d = offset_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q  <= '0;
      full_q    <= 1'b0;
      wrapped_q <= 1'b0;
      bd_q      <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      full_q    <= full_d;
      wrapped_q <= wrapped_d;
      bd_q      <= bd_d;
    end
  end

  assign offset_o      = offset_q;
  assign full_o        = full_q;
  assign wrapped_o     = wrapped_q;
  assign buffer_done_o = bd_q;

endmodule

// File: rtl/wb_daq_sram_writer.sv
// DAQ channel consumer: pops packed sample words and writes them as a Wishbone master into an SRAM window.
module wb_daq_sram_writer
  import wb_daq_sram_writer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        wrap_en,
  input  logic [AW-1:0]               base_addr,
  input  logic [LW-1:0]               length,
  input  logic                        start_sram,
  input  logic [31:0]                 data_out,
  output logic                        data_done,
  wb_daq_sram_writer_if.master        wbm,
  output logic [LW-1:0]               offset,
  output logic                        full,
  output logic                        wrapped,
  output logic                        buffer_done
);

  wr_state_e   state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        accept;
  logic        clr_ok;
  logic        ptr_last;
  logic        in_wr;

  wb_daq_wr_pointer #(.LW(LW)) u_ptr (
    .clk_i         (wb_clk),
    .rst_ni        (wb_rst_n),
    .clear_i       (clr_ok),
    .adv_i         (accept),
    .wrap_en_i     (wrap_en),
    .length_i      (length),
    .offset_o      (offset),
    .last_o        (ptr_last),
    .full_o        (full),
    .wrapped_o     (wrapped),
    .buffer_done_o (buffer_done)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    accept  = 1'b0;
    clr_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_ok = clear;
        if (enable && (length != '0) && start_sram) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d  = data_out;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (wbm.wbm_ack_i) begin
          accept  = 1'b1;
          state_d = (ptr_last && !wrap_en) ? ST_FULL : ST_DONE;
        end
      end
      // turnaround cycle lets the channel advance its FIFO before we resample
      ST_DONE: begin
        state_d = (enable && start_sram) ? ST_CAPTURE : ST_IDLE;
      end
      ST_FULL: begin
        if (clear) begin
          clr_ok  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // bus outputs decode straight from the state register so reset drops cyc immediately
  assign in_wr     = (state_q == ST_WRITE);
  assign data_done = (state_q == ST_CAPTURE);

  assign wbm.wbm_cyc_o = in_wr;
  assign wbm.wbm_stb_o = in_wr;
  assign wbm.wbm_we_o  = in_wr;
  assign wbm.wbm_sel_o = in_wr ? SEL_ALL : 4'h0;
  assign wbm.wbm_dat_o = in_wr ? data_q : 32'h0;
  assign wbm.wbm_adr_o = in_wr ? ((base_addr & ~AW'(3)) + AW'({offset, 2'b00})) : '0;

endmodule
